// File: rtl/mem_arbiter_pkg.sv
// Shared core package: bus width, load/store funct3 encodings and arbiter types.
package mem_arbiter_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;

  localparam logic [2:0] FUNCT3_LOAD_B   = 3'd0;
  localparam logic [2:0] FUNCT3_LOAD_H   = 3'd1;
  localparam logic [2:0] FUNCT3_LOAD_W   = 3'd2;
  localparam logic [2:0] FUNCT3_LOAD_BU  = 3'd4;
  localparam logic [2:0] FUNCT3_LOAD_HU  = 3'd5;
  localparam logic [2:0] FUNCT3_STORE_B  = 3'd0;
  localparam logic [2:0] FUNCT3_STORE_H  = 3'd1;
  localparam logic [2:0] FUNCT3_STORE_W  = 3'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2,
    ERR_RSP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_LSU = 1'b1
  } arb_owner_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } acc_size_e;

  // Memory command latched at grant and held until the memory accepts it.
  typedef struct packed {
    logic                  we;
    logic [DATA_WIDTH-1:0] addr;
    logic [BE_WIDTH-1:0]   be;
    logic [DATA_WIDTH-1:0] wdata;
  } mem_cmd_t;

  // Unknown encodings (3, 6, 7) fall through to word size.
  function automatic acc_size_e access_size(input logic [2:0] funct3);
    case (funct3)
      FUNCT3_LOAD_B, FUNCT3_LOAD_BU: return SIZE_BYTE;
      FUNCT3_LOAD_H, FUNCT3_LOAD_HU: return SIZE_HALF;
      default:                       return SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/store_be_gen.sv
// Byte-enable, lane-replicated write data and misalignment decode for LSU accesses.
module store_be_gen
  import mem_arbiter_pkg::*;
(
  input  logic                  we,
  input  logic [2:0]            funct3,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [BE_WIDTH-1:0]   be_c,
  output logic [DATA_WIDTH-1:0] wdata_c,
  output logic                  misaligned_c
);

  always_comb begin
    be_c         = '1;
    wdata_c      = wdata;
    misaligned_c = 1'b0;
    case (access_size(funct3))
      SIZE_BYTE: begin
        if (we) be_c = BE_WIDTH'(1) << addr_lo;
        wdata_c = {BE_WIDTH{wdata[7:0]}};
      end
      SIZE_HALF: begin
        if (we) be_c = BE_WIDTH'(3) << addr_lo;
        wdata_c      = {(BE_WIDTH / 2){wdata[15:0]}};
        misaligned_c = addr_lo[0];
      end
      default: begin
        misaligned_c = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the unified memory port between instruction fetch and the LSU,
// one outstanding transaction at a time, LSU priority with an IF starvation guard.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  lsu_req,
  input  logic                  lsu_we,
  input  logic [2:0]            lsu_funct3,
  input  logic [DATA_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  output logic                  lsu_gnt,
  output logic                  lsu_rvalid,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  lsu_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [BE_WIDTH-1:0]   mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [DATA_WIDTH-1:0] WORD_MASK = ~(DATA_WIDTH'(3));

  arb_state_e       state;
  arb_owner_e       owner;
  mem_cmd_t         cmd;
  logic             mem_req_q;
  logic             drop;
  logic             run;
  logic [CNT_W-1:0] starve_cnt;

  logic                  arb_idle;
  logic                  force_if;
  logic                  lsu_win;
  logic                  if_win;
  logic                  rsp_fire;
  logic [BE_WIDTH-1:0]   lsu_be;
  logic [DATA_WIDTH-1:0] lsu_wdata_rep;
  logic                  lsu_misaligned;

  store_be_gen u_store_be_gen (
    .we           (lsu_we),
    .funct3       (lsu_funct3),
    .addr_lo      (lsu_addr[1:0]),
    .wdata        (lsu_wdata),
    .be_c         (lsu_be),
    .wdata_c      (lsu_wdata_rep),
    .misaligned_c (lsu_misaligned)
  );

  // Arbitration and response steering; only grants and rvalid/rdata are combinational.
  always_comb begin
    arb_idle   = run && (state == IDLE);
    force_if   = lsu_req && if_req && (starve_cnt == CNT_W'(STARVE_LIMIT));
    lsu_win    = arb_idle && lsu_req && !force_if;
    if_win     = arb_idle && if_req && !lsu_win;
    rsp_fire   = (state == WAIT_RSP) && mem_rvalid;
    if_gnt     = if_win;
    lsu_gnt    = lsu_win;
    if_rvalid  = rsp_fire && (owner == OWNER_IF) && !drop && !if_flush;
    if_rdata   = if_rvalid ? mem_rdata : '0;
    lsu_rvalid = (rsp_fire && (owner == OWNER_LSU)) || (state == ERR_RSP);
    lsu_err    = (state == ERR_RSP);
    lsu_rdata  = (rsp_fire && (owner == OWNER_LSU) && !cmd.we) ? mem_rdata : '0;
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = cmd.we;
  assign mem_addr  = cmd.addr;
  assign mem_be    = cmd.be;
  assign mem_wdata = cmd.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWNER_IF;
      cmd        <= '0;
      mem_req_q  <= 1'b0;
      drop       <= 1'b0;
      run        <= 1'b0;
      starve_cnt <= '0;
    end else begin
      // Keeps grants off while reset is asserted, even with requests pending.
      run <= 1'b1;

      case (state)
        IDLE: begin
          if (lsu_win) begin
            owner <= OWNER_LSU;
            if (lsu_misaligned) begin
              state <= ERR_RSP;
            end else begin
              state     <= WAIT_GNT;
              mem_req_q <= 1'b1;
              cmd.we    <= lsu_we;
              cmd.addr  <= lsu_addr & WORD_MASK;
              cmd.be    <= lsu_be;
              cmd.wdata <= lsu_we ? lsu_wdata_rep : '0;
            end
          end else if (if_win) begin
            owner     <= OWNER_IF;
            state     <= WAIT_GNT;
            mem_req_q <= 1'b1;
            cmd.we    <= 1'b0;
            cmd.addr  <= if_addr & WORD_MASK;
            cmd.be    <= '1;
            cmd.wdata <= '0;
          end
        end
        WAIT_GNT: begin
          if (mem_gnt) begin
            state     <= WAIT_RSP;
            mem_req_q <= 1'b0;
          end
        end
        WAIT_RSP: begin
          if (mem_rvalid) state <= IDLE;
        end
        ERR_RSP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (if_win) begin
        starve_cnt <= '0;
      end else if (lsu_win && if_req && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end

      // A flushed fetch still completes on the bus; only its response is dropped.
      if (state == IDLE) begin
        drop <= 1'b0;
      end else if (if_flush && (owner == OWNER_IF) &&
                   ((state == WAIT_GNT) || (state == WAIT_RSP))) begin
        drop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a response scoreboard.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        lsu_req;
  logic        lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_gnt;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  typedef struct {
    bit          is_if;
    bit          err;
    bit          has_data;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_flush   (if_flush),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .lsu_req    (lsu_req),
    .lsu_we     (lsu_we),
    .lsu_funct3 (lsu_funct3),
    .lsu_addr   (lsu_addr),
    .lsu_wdata  (lsu_wdata),
    .lsu_gnt    (lsu_gnt),
    .lsu_rvalid (lsu_rvalid),
    .lsu_rdata  (lsu_rdata),
    .lsu_err    (lsu_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Start of a cycle: memory pulses and flush default low.
  task automatic tick();
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if_flush   = 1'b0;
  endtask

  task automatic monitor();
    rsp_t e;
    if (if_rvalid || lsu_rvalid) begin
      chk1("rsp_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk1("rsp_if_owner", if_rvalid, e.is_if);
        chk1("rsp_lsu_owner", lsu_rvalid, !e.is_if);
        chk1("rsp_err", lsu_err, e.err);
        if (e.has_data) chk32("rsp_rdata", e.is_if ? if_rdata : lsu_rdata, e.rdata);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk32({tag, "_outs"}, {if_gnt, if_rvalid, lsu_gnt, lsu_rvalid, lsu_err, mem_req, mem_we},
          32'd0);
    chk32({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk32({tag, "_mem_be"}, 32'(mem_be), 32'd0);
    chk32({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk32({tag, "_rdata"}, if_rdata | lsu_rdata, 32'd0);
  endtask

  // Memory side of one granted transaction: optional gnt stall, then one-cycle response.
  task automatic serve(input bit drop_reqs, input bit exp_we, input logic [31:0] exp_addr,
                       input logic [3:0] exp_be, input logic [31:0] exp_wdata, input int stall,
                       input logic [31:0] rdata, input bit flush, input bit exp_rsp);
    for (int i = 0; i <= stall; i++) begin
      tick();
      if (drop_reqs) begin
        if_req  = 1'b0;
        lsu_req = 1'b0;
      end
      mem_gnt  = (i == stall);
      if_flush = flush && (i == 1);
      #1;
      chk1("mem_req", mem_req, 1'b1);
      chk1("mem_we", mem_we, exp_we);
      chk32("mem_addr", mem_addr, exp_addr);
      chk32("mem_be", 32'(mem_be), 32'(exp_be));
      if (exp_we) chk32("mem_wdata", mem_wdata, exp_wdata);
      chk1("no_gnt_busy", if_gnt | lsu_gnt, 1'b0);
      monitor();
    end
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    #1;
    chk1("rsp_mem_req_low", mem_req, 1'b0);
    chk1("rsp_seen", if_rvalid | lsu_rvalid, exp_rsp);
    chk1("no_gnt_rsp", if_gnt | lsu_gnt, 1'b0);
    monitor();
  endtask

  task automatic fetch_basic(input string tag);
    tick();
    if_req  = 1'b1;
    if_addr = 32'h104;
    #1;
    chk1({tag, "_if_gnt"}, if_gnt, 1'b1);
    chk1({tag, "_lsu_gnt"}, lsu_gnt, 1'b0);
    sb.push_back('{is_if: 1'b1, err: 1'b0, has_data: 1'b1, rdata: 32'hDEADBEEF});
    serve(1'b1, 1'b0, 32'h104, 4'hF, 32'h0, 0, 32'hDEADBEEF, 1'b0, 1'b1);
    chk32({tag, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic lsu_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_addr,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] rdata);
    tick();
    lsu_req    = 1'b1;
    lsu_we     = we;
    lsu_funct3 = f3;
    lsu_addr   = addr;
    lsu_wdata  = wdata;
    #1;
    chk1("lsu_gnt", lsu_gnt, 1'b1);
    chk1("lsu_if_gnt", if_gnt, 1'b0);
    sb.push_back('{is_if: 1'b0, err: 1'b0, has_data: !we, rdata: rdata});
    serve(1'b1, we, exp_addr, exp_be, exp_wdata, 0, rdata, 1'b0, 1'b1);
  endtask

  task automatic misaligned(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    tick();
    lsu_req    = 1'b1;
    lsu_we     = we;
    lsu_funct3 = f3;
    lsu_addr   = addr;
    #1;
    chk1("mis_gnt", lsu_gnt, 1'b1);
    sb.push_back('{is_if: 1'b0, err: 1'b1, has_data: 1'b0, rdata: 32'h0});
    tick();
    lsu_req = 1'b0;
    #1;
    chk1("mis_mem_req", mem_req, 1'b0);
    chk1("mis_rvalid", lsu_rvalid, 1'b1);
    chk1("mis_err", lsu_err, 1'b1);
    monitor();
    tick();
    #1;
    chk1("mis_rvalid_once", lsu_rvalid, 1'b0);
    chk1("mis_err_once", lsu_err, 1'b0);
    chk1("mis_mem_req_after", mem_req, 1'b0);
  endtask

  initial begin
    bit exp_lsu;
    rst_n      = 1'b0;
    if_req     = 1'b0;
    if_addr    = '0;
    if_flush   = 1'b0;
    lsu_req    = 1'b0;
    lsu_we     = 1'b0;
    lsu_funct3 = '0;
    lsu_addr   = '0;
    lsu_wdata  = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;

    // Reset, then a single fetch.
    tick();
    #1;
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    fetch_basic("fetch1");

    // Stores and loads: byte, half, unknown funct3 as word, byte load, word load.
    lsu_txn(1'b1, 3'd0, 32'h203, 32'h000000AB, 32'h200, 4'b1000, 32'hABABABAB, 32'h0);
    lsu_txn(1'b1, 3'd1, 32'h202, 32'h00001234, 32'h200, 4'b1100, 32'h12341234, 32'h0);
    lsu_txn(1'b1, 3'd3, 32'h208, 32'hCAFEF00D, 32'h208, 4'hF, 32'hCAFEF00D, 32'h0);
    lsu_txn(1'b0, 3'd4, 32'h205, 32'h0, 32'h204, 4'hF, 32'h0, 32'h11223344);
    lsu_txn(1'b0, 3'd2, 32'h20C, 32'h0, 32'h20C, 4'hF, 32'h0, 32'h55AA00FF);

    // Contention: both held high, IF forced through after four LSU wins.
    if_addr    = 32'h400;
    lsu_we     = 1'b0;
    lsu_funct3 = 3'd2;
    lsu_addr   = 32'h300;
    for (int k = 0; k < 6; k++) begin
      exp_lsu = (k != 4);
      tick();
      if_req  = 1'b1;
      lsu_req = 1'b1;
      #1;
      chk1("cont_lsu_gnt", lsu_gnt, exp_lsu);
      chk1("cont_if_gnt", if_gnt, !exp_lsu);
      sb.push_back('{is_if: !exp_lsu, err: 1'b0, has_data: 1'b1, rdata: 32'(32'h1000 + k)});
      serve(1'b0, 1'b0, exp_lsu ? 32'h300 : 32'h400, 4'hF, 32'h0, 0, 32'(32'h1000 + k),
            1'b0, 1'b1);
    end
    tick();
    if_req  = 1'b0;
    lsu_req = 1'b0;
    #1;
    chk32("cont_drained", 32'(sb.size()), 32'd0);

    // Misaligned word load, half load and word store.
    misaligned(1'b0, 3'd2, 32'h102);
    misaligned(1'b0, 3'd5, 32'h101);
    misaligned(1'b1, 3'd2, 32'h201);

    // Flush during a stalled fetch: bus completes, response is dropped.
    tick();
    if_req  = 1'b1;
    if_addr = 32'h500;
    #1;
    chk1("flush_gnt", if_gnt, 1'b1);
    serve(1'b1, 1'b0, 32'h500, 4'hF, 32'h0, 3, 32'h0BAD0BAD, 1'b1, 1'b0);

    // Flush while idle is ignored and the drop flag has cleared.
    tick();
    if_req   = 1'b1;
    if_addr  = 32'h600;
    if_flush = 1'b1;
    #1;
    chk1("post_flush_gnt", if_gnt, 1'b1);
    sb.push_back('{is_if: 1'b1, err: 1'b0, has_data: 1'b1, rdata: 32'h00600600});
    serve(1'b1, 1'b0, 32'h600, 4'hF, 32'h0, 0, 32'h00600600, 1'b0, 1'b1);

    // Reset while waiting for the response, with a fetch request still pending.
    tick();
    if_req  = 1'b1;
    if_addr = 32'h704;
    #1;
    chk1("rst_fetch_gnt", if_gnt, 1'b1);
    tick();
    mem_gnt = 1'b1;
    #1;
    chk1("rst_mem_req", mem_req, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    if_req = 1'b0;
    #1;
    check_all_zero("midrst_hold");
    tick();
    rst_n = 1'b1;
    fetch_basic("fetch2");

    chk32("final_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares the core's single unified memory port between two requesters: the instruction-fetch stage (IF) and the load/store unit (LSU).
- One transaction is outstanding at a time. LSU has priority over IF, with a starvation guard for IF.
- Generates store byte enables and lane-replicated write data from the store funct3.
- Rejects misaligned LSU accesses locally, without touching memory.
- Sits between the pipeline and the memory/bus interface.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: number of consecutive LSU wins over a pending IF request before IF is forced to win.
- `DATA_WIDTH`, default 32 (shared package): data and address width.

Ports (clock and reset first):
- `clk`  in  1  system clock. Single clock; reset is asynchronous, active-low.
- `rst_n`  in  1  asynchronous active-low reset.
- `if_req`  in  1  fetch request; held until `if_gnt`.
- `if_addr`  in  32  fetch byte address. Bits [1:0] are ignored.
- `if_flush`  in  1  discard the outstanding fetch response.
- `if_gnt`  out  1  one-cycle accept pulse.
- `if_rvalid`  out  1  fetch data valid.
- `if_rdata`  out  32  fetched word.
- `lsu_req`  in  1  load/store request; held until `lsu_gnt`.
- `lsu_we`  in  1  1 = store.
- `lsu_funct3`  in  3  load/store funct3.
- `lsu_addr`  in  32  byte address.
- `lsu_wdata`  in  32  store data, right-aligned.
- `lsu_gnt`  out  1  one-cycle accept pulse.
- `lsu_rvalid`  out  1  completion; asserted for loads and stores.
- `lsu_rdata`  out  32  raw memory word; loads only.
- `lsu_err`  out  1  misaligned access; valid with `lsu_rvalid`.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  memory write.
- `mem_addr`  out  32  word address; bits [1:0] = 0.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  write data.
- `mem_gnt`  in  1  memory accepts the request.
- `mem_rvalid`  in  1  memory response (read data or write ack).
- `mem_rdata`  in  32  memory read data.

## Operation
FSM states: `IDLE`, `WAIT_GNT`, `WAIT_RSP`, `ERR_RSP`.

**IDLE: arbitration.** Combinational from the request inputs:
- Grant goes to LSU if `lsu_req` is high.
- Exception: if both `lsu_req` and `if_req` are high and the starvation counter equals `STARVE_LIMIT`, grant goes to IF.
- Otherwise grant goes to IF if `if_req` is high.
- The grant pulses `*_gnt`. Owner, address, we, be and wdata are latched.

**Starvation counter:**
- Increments on an LSU grant while `if_req` is high.
- Clears on any IF grant.
- Saturates at `STARVE_LIMIT`.

**LSU alignment.** Misaligned means: half with `addr[0]`=1, or word with `addr[1:0]`≠0.
- A misaligned LSU grant moves to `ERR_RSP`.
- `ERR_RSP` asserts `lsu_rvalid`=`lsu_err`=1 for one cycle, then returns to `IDLE`. No `mem_req` is issued.
- A valid LSU grant, or any IF grant, moves to `WAIT_GNT`.

**Byte enables.** With `a = addr[1:0]`:
- byte: `be = 4'b0001 << a`
- half: `be = 4'b0011 << a`
- word: `be = 4'hF`
- loads and IF: `be = 4'hF`

**Write data:**
- byte: `wdata[7:0]` replicated ×4.
- half: `wdata[15:0]` replicated ×2.
- word: unchanged.

**WAIT_GNT:** `mem_req`=1 with latched fields, held stable. On `mem_gnt`, move to `WAIT_RSP`.

**WAIT_RSP:** on `mem_rvalid`:
- Assert the owner's `*_rvalid` in the same cycle (combinational), with `*_rdata = mem_rdata`.
- Move to `IDLE`.

**Flush:**
- `if_flush` while IF owns the port in `WAIT_GNT` or `WAIT_RSP` sets a drop flag.
- The transaction still completes on the memory side, but `if_rvalid` is suppressed.
- The flag clears on return to `IDLE`.
- `if_flush` in `IDLE` has no effect.

**Decode errors.** Unknown funct3 (3, 6, 7) is treated as word.

## Timing
- **Reset (async, `rst_n`=0):** state=`IDLE`, counter=0, drop flag=0; all outputs 0, including `mem_addr`, `mem_be`, `mem_wdata` and rdata.
- A transaction in flight at reset is abandoned; memory is reset in the same domain.
- **Minimum latency:** gnt at T → `mem_req` at T+1 → `mem_gnt` at T+1 → `mem_rvalid` at T+2 → requester rvalid at T+2.
- **Error path:** gnt at T → `lsu_rvalid`/`lsu_err` at T+1.
- **No grant while not IDLE:** requesters keep `req` high; no grant is given while the state is not `IDLE`.
- **No new grant in the rvalid cycle:** the next grant is at the earliest cycle after it. Back-to-back throughput is one transaction per 3 cycles.
- **After grant:** requesters may change `req`/addr. The latched copies drive memory.
- **`mem_rvalid` outside `WAIT_RSP`:** ignored.
- **`mem_gnt` and `mem_rvalid` in the same cycle in `WAIT_GNT`:** not supported; memory guarantees response ≥1 cycle after grant.

## Structure
- Add to the shared core package:
  - `arb_state_e` (the FSM states).
  - `arb_owner_e` (`OWNER_IF`, `OWNER_LSU`).
  - Reuse the existing `FUNCT3_STORE_*` / `FUNCT3_LOAD_*` constants.
- Natural sub-module: `store_be_gen`. Combinational funct3 + addr[1:0] + wdata → be, replicated wdata, misaligned flag.

## Test plan
1. **Reset and single fetch.** `if_req`, `if_addr`=0x104, memory grants immediately and returns 0xDEADBEEF one cycle later. Expect `if_gnt` at T, `mem_addr`=0x104 and `mem_be`=F at T+1, `if_rvalid`=1 with 0xDEADBEEF at T+2.
2. **Store byte.** `lsu_we`=1, funct3=0, addr=0x203, wdata=0xAB. Expect `mem_be`=4'b1000, `mem_wdata`=0xABABABAB, `mem_addr`=0x200, and `lsu_rvalid` on ack.
3. **Contention and starvation.** `if_req` and `lsu_req` held high continuously, `STARVE_LIMIT`=4. Expect grants LSU,LSU,LSU,LSU,IF,LSU…
4. **Misaligned.** Load-word at 0x102. Expect `lsu_rvalid`=`lsu_err`=1 one cycle after gnt, and no `mem_req`.
5. **Flush.** Fetch granted, memory stalls `mem_gnt` for 3 cycles, `if_flush` pulsed during the stall. Expect `mem_req` held stable, then no `if_rvalid` on response, and `IDLE` afterward.
6. **Reset mid-operation.** Assert `rst_n`=0 in `WAIT_RSP`. Expect all outputs 0 immediately, and a fresh fetch after release behaving as in scenario 1.
